// File: rtl/spi_master_gen.sv
// spi_master_gen : single-frame SPI master, all four SPI modes, registered outputs.
//
// Parameters
//   DATA_W  : bits per frame (4..32), shifted MSB first
//   NUM_SS  : number of slave selects (1..8)
//   CLK_DIV : clk cycles per SCLK half-period (>= 2)
//
// Ports
//   clk, rst_n    : system clock (rising edge), asynchronous active-low reset
//   start_bit     : transfer request, taken only in IDLE with an in-range ss_sel
//   data_sent     : frame to transmit, latched on accept
//   MODE          : {CPOL, CPHA}, latched on accept
//   ss_sel        : slave index, latched on accept
//   miso          : serial data from the slave
//   sclk, mosi    : serial clock and data to the slave
//   ss_n          : active-low selects, one-hot-low while a frame is in flight
//   busy          : high from the cycle after accept until the return to IDLE
//   done          : one-cycle pulse when a frame completes
//   data_received : last completed received frame
//
// Build option
//   SPI_LOOPBACK_EN : when defined the receiver samples the internal mosi
//                     instead of miso, so data_received echoes the sent frame.
//
// Frame timeline (accept in cycle T):
//   LEAD  T+1 .. CLK_DIV cycles, sclk parked at CPOL, select asserted
//   XFER  2*DATA_W sclk edges, one every CLK_DIV cycles
//   TRAIL CLK_DIV cycles, sclk back at CPOL, select still asserted
//   DONE  one cycle at T+1+(2*DATA_W+2)*CLK_DIV, select released, done=1

module spi_master_gen #(
  parameter  int DATA_W  = 8,
  parameter  int NUM_SS  = 2,
  parameter  int CLK_DIV = 4,
  localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_bit,
  input  logic [DATA_W-1:0] data_sent,
  input  logic [1:0]        MODE,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_received
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
  localparam logic [NUM_SS-1:0] SS_ONE    = NUM_SS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_TRAIL,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              cpol_q, cpha_q;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              sclk_r, mosi_r, busy_r, done_r;
  logic [NUM_SS-1:0] ss_n_r;
  logic [DATA_W-1:0] rx_data_r;

  logic sel_ok, accept, div_end, xfer_edge, lead_edge, last_edge;
  logic shift_en, sample_en, rx_in;

`ifdef SPI_LOOPBACK_EN
  // Loop the transmitter back into the receiver; the miso pin is ignored.
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_in       = mosi_r;
`else
  assign rx_in       = miso;
`endif

  // Out-of-range selects are refused outright rather than aliased.
  assign sel_ok    = (32'(ss_sel) < 32'(NUM_SS));
  assign accept    = (state_q == S_IDLE) && start_bit && sel_ok;
  assign div_end   = (div_cnt == DIV_LAST);
  assign xfer_edge = (state_q == S_XFER) && div_end;

  // edge_cnt holds the number of edges already produced, so the edge being
  // generated now is edge_cnt+1: even count -> odd (leading) edge.
  assign lead_edge = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EDGE_LAST);

  // CPHA=0: data launched on trailing edges (MSB already out at LEAD entry),
  //         captured on leading edges; no launch after the final edge.
  // CPHA=1: data launched on leading edges, captured on trailing edges.
  assign shift_en  = xfer_edge && (cpha_q ? lead_edge : (!lead_edge && !last_edge));
  assign sample_en = xfer_edge && (cpha_q ? !lead_edge : lead_edge);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LEAD;
      S_LEAD:  if (div_end) state_d = S_XFER;
      S_XFER:  if (div_end && last_edge) state_d = S_TRAIL;
      S_TRAIL: if (div_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- counters
  // div_cnt paces every timed phase; it sits at zero outside them so each
  // phase starts with a full CLK_DIV-cycle interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      if (state_q == S_LEAD || state_q == S_XFER || state_q == S_TRAIL)
        div_cnt <= div_end ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      if (state_q != S_XFER)
        edge_cnt <= '0;
      else if (div_end)
        edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      ss_n_r    <= '1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rx_data_r <= '0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_d != S_IDLE);

      case (state_q)
        S_IDLE: begin
          // Idle sclk tracks the requested polarity so the line is already
          // parked correctly when a frame starts.
          sclk_r <= MODE[1];
          mosi_r <= 1'b0;
          ss_n_r <= '1;
          if (accept) begin
            cpol_q <= MODE[1];
            cpha_q <= MODE[0];
            ss_n_r <= ~(SS_ONE << ss_sel);
            rx_sr  <= '0;
            if (MODE[0]) begin
              mosi_r <= 1'b0;
              tx_sr  <= data_sent;
            end else begin
              mosi_r <= data_sent[DATA_W-1];
              tx_sr  <= {data_sent[DATA_W-2:0], 1'b0};
            end
          end
        end

        S_LEAD: begin
          sclk_r <= cpol_q;
        end

        S_XFER: begin
          if (xfer_edge) sclk_r <= ~sclk_r;
          if (shift_en) begin
            mosi_r <= tx_sr[DATA_W-1];
            tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
          end
          if (sample_en) rx_sr <= {rx_sr[DATA_W-2:0], rx_in};
        end

        S_TRAIL: begin
          sclk_r <= cpol_q;
          if (div_end) begin
            // Entering DONE: release the slave and publish the frame.
            ss_n_r    <= '1;
            mosi_r    <= 1'b0;
            done_r    <= 1'b1;
            rx_data_r <= rx_sr;
          end
        end

        S_DONE: begin
          ss_n_r <= '1;
          mosi_r <= 1'b0;
        end

        default: begin
          ss_n_r <= '1;
          mosi_r <= 1'b0;
        end
      endcase
    end
  end

  assign sclk          = sclk_r;
  assign mosi          = mosi_r;
  assign ss_n          = ss_n_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign data_received = rx_data_r;

endmodule
